// File: rtl/bk_cmd_arbiter.sv
// Arbitrates the single DRAM command slot among NUM_REQ requesters.
// The result is registered and broadcast one cycle after selection.
module bk_cmd_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int BK_ADDR_WIDTH = 4,
  parameter int CMD_WIDTH     = 5,
  parameter int PRIO_WIDTH    = 3,
  parameter int NOP_CODE      = 0,
  parameter int AGE_MAX       = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                slot_rdy,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_lock,
  input  logic [NUM_REQ*PRIO_WIDTH-1:0]       req_prio,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]        req_cmd,
  input  logic [NUM_REQ*BK_ADDR_WIDTH-1:0]    req_bk,
  output logic [NUM_REQ-1:0]                  req_ack,
  output logic                                cmd_valid,
  output logic [CMD_WIDTH-1:0]                cmd,
  output logic [BK_ADDR_WIDTH-1:0]            cmd_bk,
  output logic [$clog2(NUM_REQ)-1:0]          cmd_src,
  output logic                                locked
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int POS_W = IDX_W + 1;
  localparam logic [CMD_WIDTH-1:0]  NOP      = CMD_WIDTH'(NOP_CODE);
  localparam logic [7:0]            AGE_LIM  = 8'(AGE_MAX);
  localparam logic [PRIO_WIDTH-1:0] PRIO_TOP = '1;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_e;

  arb_state_e                 state_q, state_d;
  logic [IDX_W-1:0]           owner_q, owner_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]         ack_q, ack_d;
  logic                       cmd_valid_q, cmd_valid_d;
  logic [CMD_WIDTH-1:0]       cmd_q, cmd_d;
  logic [BK_ADDR_WIDTH-1:0]   cmd_bk_q, cmd_bk_d;
  logic [IDX_W-1:0]           cmd_src_q, cmd_src_d;

  logic [PRIO_WIDTH-1:0]      prio_w   [NUM_REQ];
  logic [CMD_WIDTH-1:0]       cmd_w    [NUM_REQ];
  logic [BK_ADDR_WIDTH-1:0]   bk_w     [NUM_REQ];
  logic [PRIO_WIDTH-1:0]      eff_prio [NUM_REQ];
  logic [NUM_REQ-1:0]         elig;

  logic                       lock_hold;
  logic                       grant;
  logic [IDX_W-1:0]           win_idx;
  logic [PRIO_WIDTH-1:0]      best_prio;

  // The lock only holds while its owner keeps both valid and lock asserted.
  assign lock_hold = (state_q == ARB_LOCKED) && req_valid[owner_q] && req_lock[owner_q];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [7:0] age_q, age_d;
      logic       won;

      assign prio_w[gi] = req_prio[gi*PRIO_WIDTH +: PRIO_WIDTH];
      assign cmd_w[gi]  = req_cmd[gi*CMD_WIDTH +: CMD_WIDTH];
      assign bk_w[gi]   = req_bk[gi*BK_ADDR_WIDTH +: BK_ADDR_WIDTH];

      // A requester just acked still shows its stale request, so skip it once.
      assign elig[gi] = req_valid[gi] && slot_rdy && !ack_q[gi] &&
                        (!lock_hold || (owner_q == IDX_W'(gi)));

      assign eff_prio[gi] = (age_q >= AGE_LIM) ? PRIO_TOP : prio_w[gi];
      assign won          = grant && (win_idx == IDX_W'(gi));

      always_comb begin
        age_d = age_q;
        if (!req_valid[gi] || won) begin
          age_d = '0;
        end else if (age_q != 8'hFF) begin
          age_d = age_q + 8'd1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          age_q <= '0;
        end else begin
          age_q <= age_d;
        end
      end
    end
  endgenerate

  // Scan in round-robin order from rr_ptr; a strictly higher priority is needed
  // to displace an earlier candidate, so ties resolve to the first one found.
  always_comb begin : arb_select
    logic [POS_W-1:0] pos;
    logic [IDX_W-1:0] idx;
    grant     = 1'b0;
    win_idx   = '0;
    best_prio = '0;
    pos       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr_q} + POS_W'(k);
      if (pos >= POS_W'(NUM_REQ)) begin
        pos = pos - POS_W'(NUM_REQ);
      end
      idx = pos[IDX_W-1:0];
      if (elig[idx] && (!grant || (eff_prio[idx] > best_prio))) begin
        grant     = 1'b1;
        win_idx   = idx;
        best_prio = eff_prio[idx];
      end
    end
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (slot_rdy) begin
      if (lock_hold) begin
        state_d = ARB_LOCKED;
      end else if (grant && req_lock[win_idx]) begin
        state_d = ARB_LOCKED;
        owner_d = win_idx;
      end else begin
        state_d = ARB_OPEN;
      end
      // Owner grants inside a held lock leave the rotation untouched.
      if (grant && !lock_hold) begin
        rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin : out_next
    ack_d = '0;
    if (grant) begin
      ack_d[win_idx] = 1'b1;
    end
    cmd_valid_d = grant && (cmd_w[win_idx] != NOP);
    cmd_d       = grant ? cmd_w[win_idx] : NOP;
    cmd_bk_d    = grant ? bk_w[win_idx] : '0;
    cmd_src_d   = grant ? win_idx : cmd_src_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_OPEN;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      ack_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= NOP;
      cmd_bk_q    <= '0;
      cmd_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      ack_q       <= ack_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_bk_q    <= cmd_bk_d;
      cmd_src_q   <= cmd_src_d;
    end
  end

  assign req_ack   = ack_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign cmd_bk    = cmd_bk_q;
  assign cmd_src   = cmd_src_q;
  assign locked    = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_bk_cmd_arbiter.sv
// Bench for bk_cmd_arbiter: vector table, hand-written lock/aging/reset
// sequences, then random traffic against a behavioural model.
module tb_bk_cmd_arbiter;

  localparam int N   = 4;
  localparam int BKW = 4;
  localparam int CW  = 5;
  localparam int PW  = 3;
  localparam int AGE = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             slot_rdy = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_lock = '0;
  logic [N*PW-1:0]  req_prio = '0;
  logic [N*CW-1:0]  req_cmd = '0;
  logic [N*BKW-1:0] req_bk = '0;
  logic [N-1:0]     req_ack;
  logic             cmd_valid;
  logic [CW-1:0]    cmd;
  logic [BKW-1:0]   cmd_bk;
  logic [1:0]       cmd_src;
  logic             locked;

  int checks = 0;
  int failures = 0;
  bit verbose = 1'b1;

  bk_cmd_arbiter #(
    .NUM_REQ(N), .BK_ADDR_WIDTH(BKW), .CMD_WIDTH(CW), .PRIO_WIDTH(PW),
    .NOP_CODE(0), .AGE_MAX(AGE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .slot_rdy(slot_rdy),
    .req_valid(req_valid), .req_lock(req_lock), .req_prio(req_prio),
    .req_cmd(req_cmd), .req_bk(req_bk), .req_ack(req_ack),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bk(cmd_bk), .cmd_src(cmd_src),
    .locked(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Behavioural model: whole-cycle rules on integers.
  int         m_age [N];
  int         m_rr;
  bit         m_lk;
  int         m_own;
  logic [N-1:0]   m_ack;
  logic           m_cv;
  logic [CW-1:0]  m_cmd;
  logic [BKW-1:0] m_bk;
  logic [1:0]     m_src;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_age[i] = 0;
    m_rr = 0; m_lk = 0; m_own = 0;
    m_ack = '0; m_cv = 0; m_cmd = '0; m_bk = '0; m_src = '0;
  endtask

  task automatic model_step();
    bit hold;
    int best, be, bd, e, d;
    hold = m_lk && req_valid[m_own] && req_lock[m_own];
    best = -1; be = -1; bd = N;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && slot_rdy && !m_ack[i] && (!hold || i == m_own)) begin
        e = (m_age[i] >= AGE) ? 7 : int'(req_prio[i*PW +: PW]);
        d = (i - m_rr + N) % N;
        if (e > be || (e == be && d < bd)) begin
          best = i; be = e; bd = d;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || i == best) m_age[i] = 0;
      else if (m_age[i] < 255) m_age[i] = m_age[i] + 1;
    end
    if (slot_rdy && !hold) begin
      if (best >= 0) m_rr = (best + 1) % N;
      m_lk = (best >= 0) && req_lock[best];
      if (m_lk) m_own = best;
    end
    m_ack = '0;
    if (best >= 0) begin
      m_ack[best] = 1'b1;
      m_cmd = req_cmd[best*CW +: CW];
      m_cv  = (m_cmd != '0);
      m_bk  = req_bk[best*BKW +: BKW];
      m_src = 2'(best);
    end else begin
      m_cv = 0; m_cmd = '0; m_bk = '0;
    end
  endtask

  task automatic tick();
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [N-1:0] ea, logic ecv, logic [CW-1:0] ec,
                       logic [BKW-1:0] eb, logic [1:0] es, logic el);
    checks++;
    if ({req_ack, cmd_valid, cmd, cmd_bk, cmd_src, locked} !== {ea, ecv, ec, eb, es, el}) begin
      failures++;
      $display("FAIL %s: got ack=%b cv=%b cmd=%0d bk=%0d src=%0d lk=%b, need ack=%b cv=%b cmd=%0d bk=%0d src=%0d lk=%b",
               name, req_ack, cmd_valid, cmd, cmd_bk, cmd_src, locked, ea, ecv, ec, eb, es, el);
    end else if (verbose) begin
      $display("chk %s ack=%b cv=%b cmd=%0d bk=%0d src=%0d lk=%b",
               name, req_ack, cmd_valid, cmd, cmd_bk, cmd_src, locked);
    end
  endtask

  task automatic set_req(int i, bit v, bit lk, int p, int c, int b);
    req_valid[i] = v;
    req_lock[i]  = lk;
    req_prio[i*PW +: PW]  = PW'(p);
    req_cmd[i*CW +: CW]   = CW'(c);
    req_bk[i*BKW +: BKW]  = BKW'(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    slot_rdy = 0; req_valid = '0; req_lock = '0; req_prio = '0; req_cmd = '0; req_bk = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic           slot;
    logic [N-1:0]   v;
    logic [N-1:0]   lk;
    logic [N*PW-1:0]  prio;
    logic [N*CW-1:0]  cmdv;
    logic [N*BKW-1:0] bk;
    logic [N-1:0]   e_ack;
    logic           e_cv;
    logic [CW-1:0]  e_cmd;
    logic [BKW-1:0] e_bk;
    logic [1:0]     e_src;
    logic           e_lk;
  } vec_t;

  function automatic vec_t mk(logic [N-1:0] v, logic [N*PW-1:0] p, logic [N*CW-1:0] c,
                              logic [N*BKW-1:0] b, logic [N-1:0] ea, logic ecv,
                              int ec, int eb, int es);
    vec_t r;
    r.slot = 1'b1; r.v = v; r.lk = '0; r.prio = p; r.cmdv = c; r.bk = b;
    r.e_ack = ea; r.e_cv = ecv; r.e_cmd = CW'(ec); r.e_bk = BKW'(eb);
    r.e_src = 2'(es); r.e_lk = 1'b0;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [N*PW-1:0]  p_all2, p_t2;
    logic [N*CW-1:0]  c_all1, c_t1, c_t2;
    logic [N*BKW-1:0] b_t3, b_t1, b_t2;
    int exp5[8];

    p_all2 = {4{3'd2}};
    c_all1 = {4{5'd1}};
    b_t3   = {4'd11, 4'd10, 4'd9, 4'd8};
    c_t1   = {5'd0, 5'd0, 5'd0, 5'd1};
    b_t1   = {4'd0, 4'd0, 4'd0, 4'd5};
    p_t2   = {3'd0, 3'd3, 3'd7, 3'd0};
    c_t2   = {5'd0, 5'd1, 5'd1, 5'd0};
    b_t2   = {4'd0, 4'd3, 4'd2, 4'd0};

    // Round-robin from rr=0 with equal priorities: 0,1,2,3,0.
    tbl.push_back(mk(4'hF, p_all2, c_all1, b_t3, 4'b0001, 1, 1, 8, 0));
    tbl.push_back(mk(4'hF, p_all2, c_all1, b_t3, 4'b0010, 1, 1, 9, 1));
    tbl.push_back(mk(4'hF, p_all2, c_all1, b_t3, 4'b0100, 1, 1, 10, 2));
    tbl.push_back(mk(4'hF, p_all2, c_all1, b_t3, 4'b1000, 1, 1, 11, 3));
    tbl.push_back(mk(4'hF, p_all2, c_all1, b_t3, 4'b0001, 1, 1, 8, 0));
    tbl.push_back(mk(4'h0, p_all2, c_all1, b_t3, 4'b0000, 0, 0, 0, 0));
    // Single requester held valid: ack every other cycle.
    tbl.push_back(mk(4'h1, '0, c_t1, b_t1, 4'b0001, 1, 1, 5, 0));
    tbl.push_back(mk(4'h1, '0, c_t1, b_t1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(4'h1, '0, c_t1, b_t1, 4'b0001, 1, 1, 5, 0));
    tbl.push_back(mk(4'h1, '0, c_t1, b_t1, 4'b0000, 0, 0, 0, 0));
    // Priority: req1 (7) before req2 (3), then req2 while req1 is masked.
    tbl.push_back(mk(4'h6, p_t2, c_t2, b_t2, 4'b0010, 1, 1, 2, 1));
    tbl.push_back(mk(4'h6, p_t2, c_t2, b_t2, 4'b0100, 1, 1, 3, 2));
    tbl.push_back(mk(4'h0, p_t2, c_t2, b_t2, 4'b0000, 0, 0, 0, 2));

    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      slot_rdy = tbl[r].slot; req_valid = tbl[r].v; req_lock = tbl[r].lk;
      req_prio = tbl[r].prio; req_cmd = tbl[r].cmdv; req_bk = tbl[r].bk;
      tick();
      check($sformatf("vec%0d", r), tbl[r].e_ack, tbl[r].e_cv, tbl[r].e_cmd,
            tbl[r].e_bk, tbl[r].e_src, tbl[r].e_lk);
    end

    // Locked refresh sequence with NOP and PREAB (2); req1 must wait.
    do_reset();
    slot_rdy = 1;
    set_req(0, 1, 1, 7, 0, 0);
    set_req(1, 1, 0, 7, 1, 1);
    tick(); check("lock_nop_grant", 4'b0001, 0, 0, 0, 0, 1);
    set_req(0, 1, 1, 7, 2, 0);
    tick(); check("lock_mask", 4'b0000, 0, 0, 0, 0, 1);
    tick(); check("lock_preab", 4'b0001, 1, 2, 0, 0, 1);
    set_req(0, 1, 1, 7, 0, 0);
    tick(); check("lock_mask2", 4'b0000, 0, 0, 0, 0, 1);
    tick(); check("lock_nop2", 4'b0001, 0, 0, 0, 0, 1);
    set_req(0, 0, 0, 7, 0, 0);
    tick(); check("lock_release", 4'b0010, 1, 1, 1, 1, 0);

    // Aging: req0 (prio 0) starved by req1/req2 (prio 7) until promoted.
    do_reset();
    slot_rdy = 1;
    set_req(0, 1, 0, 0, 1, 0);
    set_req(1, 1, 0, 7, 1, 1);
    set_req(2, 1, 0, 7, 1, 2);
    exp5 = '{1, 2, 1, 2, 0, 1, 2, 1};
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("age%0d", k), 4'(1 << exp5[k]), 1, 1, 4'(exp5[k]), 2'(exp5[k]), 0);
    end

    // Stall, then reset asserted in the middle of an ack pulse.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 2, 1, i + 4);
    slot_rdy = 0;
    for (int k = 0; k < 10; k++) begin
      tick(); check($sformatf("stall%0d", k), 4'b0000, 0, 0, 0, 0, 0);
    end
    slot_rdy = 1;
    tick(); check("post_stall", 4'b0001, 1, 1, 4, 0, 0);
    rst_n = 0;
    model_reset();
    #1; check("async_rst", 4'b0000, 0, 0, 0, 0, 0);
    tick(); check("in_rst", 4'b0000, 0, 0, 0, 0, 0);
    rst_n = 1;
    tick(); check("first_after_rst", 4'b0001, 1, 1, 4, 0, 0);

    // Random traffic against the model, with occasional resets.
    verbose = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      slot_rdy  = ($urandom_range(0, 9) != 0);
      req_valid = N'($urandom);
      req_lock  = N'($urandom & $urandom);
      for (int i = 0; i < N; i++) begin
        req_prio[i*PW +: PW] = PW'($urandom);
        req_cmd[i*CW +: CW]  = CW'($urandom_range(0, 3));
        req_bk[i*BKW +: BKW] = BKW'($urandom);
      end
      tick();
      check($sformatf("rand%0d", c), m_ack, m_cv, m_cmd, m_bk, m_src, m_lk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bk_cmd_arbiter.md
Name: bk_cmd_arbiter

Overview:
- Shares the single DRAM command slot among NUM_REQ requesters: refresh handler, AiM engine and per-bank engines.
- Each cycle, selects one pending request by priority. Ties are broken round-robin. Long-waiting requesters age up to maximum priority.
- A requester may lock the slot for multi-command sequences, e.g. PREAB+REFAB+MRS.
- Registered output: the ack is returned to the winner and the command is broadcast to all blocks for bank-state and timing tracking.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- BK_ADDR_WIDTH, 4, bank address width.
- CMD_WIDTH, 5, width of the command encoding.
- PRIO_WIDTH, 3, request priority width; all-ones is the maximum.
- NOP_CODE, 0, command encoding of an empty (NOP1) request.
- AGE_MAX, 64, wait cycles after which a request is promoted to maximum priority (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- slot_rdy  in  1  the downstream command slot can accept a command this cycle
- req_valid  in  NUM_REQ  per-requester request
- req_lock  in  NUM_REQ  requester asks to hold the slot after its grant
- req_prio  in  NUM_REQ*PRIO_WIDTH  per-requester priority, packed with requester 0 in the LSBs
- req_cmd  in  NUM_REQ*CMD_WIDTH  per-requester command, packed
- req_bk  in  NUM_REQ*BK_ADDR_WIDTH  per-requester bank, packed
- req_ack  out  NUM_REQ  one-hot grant pulse
- cmd_valid  out  1  broadcast: a non-NOP command was issued
- cmd  out  CMD_WIDTH  broadcast command; NOP_CODE when nothing was issued
- cmd_bk  out  BK_ADDR_WIDTH  broadcast bank
- cmd_src  out  $clog2(NUM_REQ)  index of the granted requester
- locked  out  1  the slot is held by a locked requester

Behaviour:

Reset:
- Clocking: one clock, clk; asynchronous active-low reset, rst_n.
- While rst_n is low: req_ack=0, cmd_valid=0, cmd=NOP_CODE, cmd_bk=0, cmd_src=0, locked=0.
- Also cleared: RR pointer=0, all age counters=0, FSM=ARB_OPEN.
- Reset mid-grant discards the pending grant; no ack is emitted after reset release until a new selection is made.

Latency and output pulse:
- Selection happens in cycle t; outputs are registered and visible in t+1.
- req_ack, cmd_valid, cmd, cmd_bk and cmd_src are driven for exactly one cycle per grant.
- With no grant they return to 0 / NOP_CODE (cmd_src holds its last value).

Eligibility in cycle t:
- A requester is eligible if req_valid[i]=1, slot_rdy=1, and req_ack[i]=0 in cycle t.
- The req_ack mask exists because the requester has not yet updated its stale request. Consequence: a given requester is granted at most every other cycle.

Effective priority:
- If age[i] ≥ AGE_MAX, effective priority is all-ones; otherwise it is req_prio[i].
- The winner is the highest effective priority. Ties go to the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
- On a grant, rr_ptr = winner+1, wrapping to 0 after NUM_REQ-1.

Age counter (8-bit per requester):
- Cleared when the requester is granted or when req_valid=0.
- Incremented when valid and not granted, including while slot_rdy=0 or while the slot is locked.
- Saturates at 255.

NOP requests:
- A grant whose req_cmd equals NOP_CODE still pulses req_ack.
- It drives cmd_valid=0 and cmd=NOP_CODE. This lets a requester occupy the slot or flush others.

FSM:
- ARB_OPEN: normal arbitration. If the winner has req_lock=1 at selection, go to ARB_LOCKED with owner = winner; locked=1 from t+1.
- ARB_LOCKED: only the owner is eligible; others are masked and keep aging. Return to ARB_OPEN when the owner's req_valid=0 or req_lock=0; arbitration among all requesters resumes in that same cycle.
- A grant to the owner does not advance rr_ptr.

Other boundaries:
- slot_rdy=0: no selection and no state change except aging.
- All requests invalid: no output pulse.
- NUM_REQ not a power of 2: rr_ptr wraps at NUM_REQ.
- Simultaneous aged requesters: resolved by RR among them.

Test Plan:
1. Single requester, every cycle: req0 valid with cmd=ACT, bk=5, slot_rdy=1 held → req_ack[0] pulses every second cycle, cmd_valid=1, cmd_bk=5, cmd_src=0.
2. Priority: req1 prio=7 and req2 prio=3, both valid → req1 is granted first at t+1; req2 is granted at t+2 (req1 masked).
3. Round-robin: req0..3 all prio=2 and continuously valid, rr_ptr=0 → grant order 0,1,2,3,0.
4. Lock with NOP: req0 is the refresh handler (prio=7, lock=1) alternating NOP and PREAB; req1 valid with prio=7.
   - req1 gets no ack while lock=1 and locked=1.
   - The NOP grant gives cmd_valid=0; the PREAB grant gives cmd_valid=1.
   - After lock drops, req1 is granted within 2 cycles.
5. Aging: AGE_MAX=4; req0 prio=0 valid while req1 prio=7 is constantly re-asserted → req0 is granted within 6 cycles of assertion, and its age clears to 0.
6. Reset and stall: hold slot_rdy=0 for 10 cycles with requests valid → no acks. Assert rst_n=0 mid-pulse → all outputs 0 immediately, and the first ack appears 1 cycle after rst_n=1 and slot_rdy=1.
